// File: rtl/ap_set_arbiter_pkg.sv
// Shared definitions for the AP pointer-select arbiter.
//  AP_SET_W   : width of AP's APSet input (default request code width)
//  AP_SEL_W   : width of AP's APSel readback
//  AP_SEL_MAX : largest code AP can actually select; anything above is rejected
//  ap_state_e : arbiter FSM states
package ap_pkg;
    localparam int         AP_SET_W   = 4;
    localparam int         AP_SEL_W   = 3;
    localparam logic [2:0] AP_SEL_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } ap_state_e;
endpackage

// File: rtl/ap_set_arbiter_if.sv
// Bundle between the requesters/AP and the arbiter.
//  req     : level request per requester
//  req_set : packed request codes, slice i = [i*SET_W +: SET_W]
//  ap_sel  : APSel readback from AP
//  ap_set  : APSet drive to AP
//  gnt     : one-hot completion pulse
//  err     : qualifies gnt (bad code or readback mismatch)
//  busy    : arbiter owns AP
// master = requester/AP side, slave = arbiter side.
interface ap_set_arbiter_if
    import ap_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int SET_W = AP_SET_W
);
    logic [NREQ-1:0]       req;
    logic [NREQ*SET_W-1:0] req_set;
    logic [AP_SEL_W-1:0]   ap_sel;
    logic [SET_W-1:0]      ap_set;
    logic [NREQ-1:0]       gnt;
    logic                  err;
    logic                  busy;

    modport master (output req, req_set, ap_sel, input ap_set, gnt, err, busy);
    modport slave  (input req, req_set, ap_sel, output ap_set, gnt, err, busy);
endinterface

// File: rtl/ap_set_arbiter_rr_arbiter.sv
// Combinational round-robin pick.
//  req    : request vector
//  ptr    : highest-priority position this round
//  gnt_oh : one-hot winner (all zero when req==0)
//  idx    : binary index of the winner
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt_oh,
    output logic [IDX_W-1:0] idx
);
    logic             found;
    logic [IDX_W-1:0] pos;

    // Scan positions ptr, ptr+1, ... wrapping; first set bit wins.
    always_comb begin
        gnt_oh = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = IDX_W'((int'(ptr) + i) % NREQ);
            if (!found && req[pos]) begin
                found       = 1'b1;
                gnt_oh[pos] = 1'b1;
                idx         = pos;
            end
        end
    end
endmodule

// File: rtl/ap_set_arbiter.sv
// Arbitrates access to AP's pointer-select unit. The winning code is driven
// onto ap_set, AP registers it, the readback ap_sel is verified, the winner
// gets a one-cycle gnt (err flags a bad code or readback), and the selection
// is held for HOLD_CYC cycles before the next arbitration.
//  clk : rising-edge clock
//  rst : asynchronous active-low reset
//  bus : slave side of ap_set_arbiter_if (req, req_set, ap_sel in;
//        ap_set, gnt, err, busy out)
module ap_set_arbiter
    import ap_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int SET_W    = AP_SET_W,
    parameter int HOLD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    ap_set_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

    ap_state_e           state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [SET_W-1:0]    ap_set_q, ap_set_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]     win_q, win_d;
    logic [AP_SEL_W-1:0] code_q, code_d;

    logic [NREQ-1:0]     pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic [SET_W-1:0]    codes [NREQ];
    logic [SET_W-1:0]    pick_code;

    function automatic logic code_valid(input logic [SET_W-1:0] c);
        return c <= SET_W'(AP_SEL_MAX);
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .req    (bus.req),
        .ptr    (ptr_q),
        .gnt_oh (pick_oh),
        .idx    (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            codes[i] = bus.req_set[i*SET_W +: SET_W];
        end
    end

    assign pick_code = codes[pick_idx];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        ap_set_d = ap_set_q;
        gnt_d    = '0;
        err_d    = 1'b0;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        code_d   = code_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    ptr_d = next_ptr(pick_idx);
                    win_d = pick_oh;
                    if (code_valid(pick_code)) begin
                        ap_set_d = pick_code;
                        code_d   = pick_code[AP_SEL_W-1:0];
                        busy_d   = 1'b1;
                        state_d  = LOAD;
                    end else begin
                        // Unselectable code: reject at once, AP untouched.
                        gnt_d = pick_oh;
                        err_d = 1'b1;
                    end
                end
            end
            // AP registers ap_set on the edge leaving LOAD.
            LOAD: state_d = CHECK;
            CHECK: begin
                gnt_d = win_q;
                err_d = (bus.ap_sel != code_q);
                if (HOLD_CYC > 0) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            // First HOLD cycle carries the gnt pulse; HOLD_CYC dwell cycles follow.
            HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYC)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            ap_set_q <= '0;
            gnt_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ap_set_q <= ap_set_d;
            gnt_q    <= gnt_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    // Latched winner/code are only consumed after a fresh IDLE acceptance.
    always_ff @(posedge clk) begin
        win_q  <= win_d;
        code_q <= code_d;
    end

    assign bus.ap_set = ap_set_q;
    assign bus.gnt    = gnt_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_ap_set_arbiter.sv
// Directed bench for ap_set_arbiter with a simple AP model that registers
// ap_set into ap_sel each clock (optionally forced to 0).
module tb_ap_set_arbiter;
    import ap_pkg::*;

    localparam int NREQ     = 4;
    localparam int SET_W    = 4;
    localparam int HOLD_CYC = 2;

    logic clk;
    logic rst;
    bit   force_sel0;
    int   total;
    int   bad;

    ap_set_arbiter_if #(.NREQ(NREQ), .SET_W(SET_W)) bus ();

    ap_set_arbiter #(.NREQ(NREQ), .SET_W(SET_W), .HOLD_CYC(HOLD_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) bus.ap_sel <= force_sel0 ? 3'd0 : bus.ap_set[2:0];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_code(input int idx, input logic [SET_W-1:0] code);
        bus.req_set[idx*SET_W +: SET_W] = code;
    endtask

    task automatic do_reset();
        bus.req     = '0;
        bus.req_set = '0;
        force_sel0  = 1'b0;
        rst         = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_gnt(output logic [NREQ-1:0] g, output logic [SET_W-1:0] a,
                            output logic e, output int lat, output bit ok);
        ok = 1'b0; g = '0; a = '0; e = 1'b0; lat = 0;
        for (int n = 0; n < 12 && !ok; n++) begin
            tick();
            if (bus.gnt !== '0) begin
                ok = 1'b1; g = bus.gnt; a = bus.ap_set; e = bus.err; lat = n + 1;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.ap_set !== 4'd0) begin bad++; $display("FAIL reset_ap_set: got %0h want 0", bus.ap_set); end
        total++; if (bus.gnt !== 4'd0) begin bad++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_single();
        int bcnt;
        do_reset();
        set_code(0, 4'd5);
        bus.req = 4'b0001;
        tick(); // E0
        bus.req = '0;
        bcnt = int'(bus.busy);
        total++; if (bus.ap_set !== 4'd5) begin bad++; $display("FAIL single_ap_set: got %0h want 5", bus.ap_set); end
        total++; if (bus.gnt !== 4'd0) begin bad++; $display("FAIL single_gnt_e0: got %b want 0000", bus.gnt); end
        tick(); // E1
        bcnt += int'(bus.busy);
        total++; if (bus.gnt !== 4'd0) begin bad++; $display("FAIL single_gnt_e1: got %b want 0000", bus.gnt); end
        tick(); // E2
        bcnt += int'(bus.busy);
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt_e2: got %b want 0001", bus.gnt); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", bus.err); end
        for (int k = 0; k < 7; k++) begin
            tick();
            bcnt += int'(bus.busy);
            if (k == 0) begin
                total++; if (bus.gnt !== 4'd0) begin bad++; $display("FAIL single_gnt_pulse: got %b want 0000", bus.gnt); end
            end
        end
        total++; if (bcnt != 5) begin bad++; $display("FAIL single_busy_len: got %0d want 5", bcnt); end
        total++; if (bus.ap_set !== 4'd5) begin bad++; $display("FAIL single_ap_set_held: got %0h want 5", bus.ap_set); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0]  exp_g [4];
        logic [SET_W-1:0] exp_a [4];
        int               exp_l [4];
        logic [NREQ-1:0]  g;
        logic [SET_W-1:0] a;
        logic             e;
        int               lat;
        bit               ok;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b0001;
        exp_a[0] = 4'd1;    exp_a[1] = 4'd2;    exp_a[2] = 4'd3;    exp_a[3] = 4'd1;
        exp_l[0] = 3;       exp_l[1] = 6;       exp_l[2] = 6;       exp_l[3] = 6;
        do_reset();
        set_code(0, 4'd1); set_code(1, 4'd2); set_code(2, 4'd3);
        bus.req = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(g, a, e, lat, ok);
            total++; if (!ok) begin bad++; $display("FAIL rr_timeout[%0d]: got no gnt want gnt", k); end
            total++; if (g !== exp_g[k]) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, g, exp_g[k]); end
            total++; if (a !== exp_a[k]) begin bad++; $display("FAIL rr_ap_set[%0d]: got %0h want %0h", k, a, exp_a[k]); end
            total++; if (e !== 1'b0) begin bad++; $display("FAIL rr_err[%0d]: got %b want 0", k, e); end
            total++; if (lat != exp_l[k]) begin bad++; $display("FAIL rr_latency[%0d]: got %0d want %0d", k, lat, exp_l[k]); end
        end
        bus.req = '0;
        repeat (6) tick();
    endtask

    task automatic test_invalid_code();
        do_reset();
        set_code(3, 4'd9);
        bus.req = 4'b1000;
        tick(); // E0
        bus.req = '0;
        total++; if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL inv_gnt: got %b want 1000", bus.gnt); end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL inv_err: got %b want 1", bus.err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL inv_busy: got %b want 0", bus.busy); end
        total++; if (bus.ap_set !== 4'd0) begin bad++; $display("FAIL inv_ap_set: got %0h want 0", bus.ap_set); end
        tick();
        total++; if (bus.gnt !== 4'd0) begin bad++; $display("FAIL inv_gnt_pulse: got %b want 0000", bus.gnt); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL inv_err_clear: got %b want 0", bus.err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL inv_busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_readback_err();
        do_reset();
        force_sel0 = 1'b1;
        set_code(0, 4'd6);
        bus.req = 4'b0001;
        tick(); // E0
        bus.req = '0;
        tick(); // E1
        tick(); // E2
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL rb_gnt: got %b want 0001", bus.gnt); end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL rb_err: got %b want 1", bus.err); end
        total++; if (bus.ap_set !== 4'd6) begin bad++; $display("FAIL rb_ap_set: got %0h want 6", bus.ap_set); end
        repeat (5) tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rb_busy_end: got %b want 0", bus.busy); end
        total++; if (bus.ap_set !== 4'd6) begin bad++; $display("FAIL rb_ap_set_held: got %0h want 6", bus.ap_set); end
        force_sel0 = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        bit seen;
        do_reset();
        set_code(0, 4'd5);
        bus.req = 4'b0001;
        tick(); // E0
        bus.req = '0;
        tick(); tick(); tick(); // E1..E3, now in HOLD
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL hold_busy_pre: got %b want 1", bus.busy); end
        #2 rst = 1'b0;
        #1;
        total++; if (bus.ap_set !== 4'd0) begin bad++; $display("FAIL hold_rst_ap_set: got %0h want 0", bus.ap_set); end
        total++; if (bus.gnt !== 4'd0) begin bad++; $display("FAIL hold_rst_gnt: got %b want 0000", bus.gnt); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL hold_rst_err: got %b want 0", bus.err); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL hold_rst_busy: got %b want 0", bus.busy); end
        tick(); tick();
        rst = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (bus.gnt !== 4'd0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL hold_no_late_gnt: got gnt want none"); end
    endtask

    task automatic test_reset_mid_load();
        bit               seen;
        logic [NREQ-1:0]  g;
        logic [SET_W-1:0] a;
        logic             e;
        int               lat;
        bit               ok;
        do_reset();
        set_code(0, 4'd3);
        bus.req = 4'b0001;
        tick(); // E0, now in LOAD
        bus.req = '0;
        #2 rst = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL load_rst_busy: got %b want 0", bus.busy); end
        total++; if (bus.ap_set !== 4'd0) begin bad++; $display("FAIL load_rst_ap_set: got %0h want 0", bus.ap_set); end
        tick();
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (bus.gnt !== 4'd0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL load_no_gnt: got gnt want none"); end
        set_code(1, 4'd4);
        bus.req = 4'b0010;
        wait_gnt(g, a, e, lat, ok);
        bus.req = '0;
        total++; if (!ok) begin bad++; $display("FAIL load_after_timeout: got no gnt want gnt"); end
        total++; if (g !== 4'b0010) begin bad++; $display("FAIL load_after_gnt: got %b want 0010", g); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL load_after_err: got %b want 0", e); end
        total++; if (a !== 4'd4) begin bad++; $display("FAIL load_after_ap_set: got %0h want 4", a); end
        total++; if (lat != 3) begin bad++; $display("FAIL load_after_latency: got %0d want 3", lat); end
        repeat (6) tick();
        // Pointer now sits at 2, so requester 0 wraps ahead of requester 1.
        bus.req = 4'b0011;
        wait_gnt(g, a, e, lat, ok);
        bus.req = '0;
        total++; if (g !== 4'b0001) begin bad++; $display("FAIL load_wrap_gnt: got %b want 0001", g); end
        total++; if (a !== 4'd3) begin bad++; $display("FAIL load_wrap_ap_set: got %0h want 3", a); end
        repeat (6) tick();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        force_sel0  = 1'b0;
        bus.req     = '0;
        bus.req_set = '0;
        #2;
        test_reset();
        test_reset_mid_hold();
        test_single();
        test_round_robin();
        test_invalid_code();
        test_readback_err();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
